// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_arb_pkg;

  localparam int NUM_REQ_DEF     = 4;
  localparam int DATA_W_DEF      = 8;
  localparam int TIMEOUT_CYC_DEF = 1024;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req_mask at or above rr_ptr, with wrap-around.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_mask,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               found,
  output logic [ID_W-1:0]    winner
);

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // Scan offsets from farthest to nearest so the nearest requester overwrites the rest.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_mask[wrap_idx(rr_ptr, i)]) begin
        found  = 1'b1;
        winner = wrap_idx(rr_ptr, i);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter feeding one UART byte serializer through a one-entry output register.
// Define ARB_TIMEOUT_EN to evict an owner that stalls for TIMEOUT_CYC cycles and pulse timeout_err.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ     = NUM_REQ_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ID_W        = id_width(NUM_REQ),
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                      clk,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_valid,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_ready,
  output logic                      busy,
  output logic [ID_W-1:0]           grant_id,
  output logic                      timeout_err
);

  if (NUM_REQ < 1 || NUM_REQ > 16 || TIMEOUT_CYC < 2) begin : g_cfg_check
    $error("uart_tx_arbiter: unsupported NUM_REQ or TIMEOUT_CYC");
  end

  arb_state_e          state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic                tx_valid_q, tx_valid_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;

  logic                pick_found;
  logic [ID_W-1:0]     pick_id;
  logic                out_free;
  logic                owner_valid;
  logic                owner_last;
  logic                owner_xfer;
  logic [DATA_W-1:0]   owner_data;
  logic [ID_W-1:0]     next_ptr;
  logic                evict;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_mask (req_valid),
    .rr_ptr   (rr_ptr_q),
    .found    (pick_found),
    .winner   (pick_id)
  );

  // The output register can take a new byte when empty or being drained this cycle.
  assign out_free    = !tx_valid_q || tx_ready;
  assign owner_valid = req_valid[grant_id_q];
  assign owner_last  = req_last[grant_id_q];
  assign owner_data  = req_data[int'(grant_id_q)*DATA_W +: DATA_W];
  assign owner_xfer  = (state_q == LOCKED) && owner_valid && out_free;
  assign next_ptr    = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             timeout_err_q, timeout_err_d;

  assign evict = (state_q == LOCKED) && !owner_valid &&
                 (stall_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    stall_cnt_d   = stall_cnt_q;
    timeout_err_d = evict;
    if (state_q != LOCKED || owner_xfer || evict) begin
      stall_cnt_d = '0;
    end else if (!owner_valid) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_i) begin
      stall_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      stall_cnt_q   <= stall_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign evict       = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    req_ready  = '0;

    if (tx_valid_q && tx_ready) tx_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_id_d = pick_id;
          state_d    = LOCKED;
        end
      end
      LOCKED: begin
        req_ready[grant_id_q] = out_free;
        if (owner_xfer) begin
          tx_valid_d = 1'b1;
          tx_data_d  = owner_data;
          if (owner_last) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end
        end else if (evict) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign grant_id = grant_id_q;
  assign busy     = (state_q == LOCKED) || tx_valid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized message traffic against a message-level round-robin model.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int IDW = 2;
`ifdef ARB_TIMEOUT_EN
  localparam int TO  = 8;
`else
  localparam int TO  = 1024;
`endif

  logic            clk = 1'b0;
  logic            rst_i;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            tx_valid;
  logic [DW-1:0]   tx_data;
  logic            tx_ready;
  logic            busy;
  logic [IDW-1:0]  grant_id;
  logic            timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ     (N),
    .DATA_W      (DW),
    .ID_W        (IDW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .rst_i       (rst_i),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  typedef logic [8:0] ent_t;  // {last, data}

  ent_t       drv_q[N][$];   // bytes each requester still has to hand over
  ent_t       pend_q[N][$];  // messages not yet ordered by the model
  logic [7:0] exp_q[$];      // expected serializer byte stream
  int         model_rr;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         first_hs_cyc[N];
  int         last_hs_cyc[N];
  int         beat_cyc[$];
  logic [N-1:0] hs_mask;
  logic [N-1:0] forbid_ready;
  logic       prev_stall;
  logic [7:0] prev_data;
  bit         rand_ready;
`ifdef ARB_TIMEOUT_EN
  int         to_pulses;
  int         to_cyc;
  logic       prev_to;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic bit drv_pending();
    for (int i = 0; i < N; i++) if (drv_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic add_byte(input int r, input logic [7:0] d, input logic last);
    drv_q[r].push_back({last, d});
    pend_q[r].push_back({last, d});
  endtask

  task automatic add_msg(input int r, input int len);
    for (int b = 0; b < len; b++) add_byte(r, 8'($urandom), (b == len - 1));
  endtask

  // Orders every pending message: round-robin from the pointer, whole messages at a time.
  task automatic model_resolve();
    int   w;
    ent_t e;
    forever begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && pend_q[(model_rr + k) % N].size() > 0) w = (model_rr + k) % N;
      end
      if (w < 0) break;
      do begin
        e = pend_q[w].pop_front();
        exp_q.push_back(e[7:0]);
      end while (!e[8]);
      model_rr = (w + 1) % N;
    end
  endtask

  task automatic drive();
    ent_t e;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (drv_q[i].size() > 0);
      if (req_valid[i]) begin
        e = drv_q[i][0];
        req_data[i*DW +: DW] = e[7:0];
        req_last[i]          = e[8];
      end else begin
        req_data[i*DW +: DW] = 8'($urandom);
        req_last[i]          = 1'($urandom);
      end
    end
  endtask

  task automatic observe();
    hs_mask = '0;
    if (!rst_i) return;
    chk("ready_onehot", 32'($countones(req_ready) <= 1), 1);
    if (tx_valid && !tx_ready) chk("ready_while_full", 32'(req_ready), 0);
    if (forbid_ready != '0) chk("ready_forbidden", 32'(req_ready & forbid_ready), 0);
    if (prev_stall) begin
      chk("hold_valid", 32'(tx_valid), 1);
      chk("hold_data", 32'(tx_data), 32'(prev_data));
    end
    if (tx_valid) chk("busy_out", 32'(busy), 1);
`ifdef ARB_TIMEOUT_EN
    if (timeout_err) begin
      to_pulses++;
      to_cyc = cyc;
      chk("to_width", 32'(prev_to), 0);
    end
    prev_to = timeout_err;
`else
    chk("to_tied", 32'(timeout_err), 0);
`endif
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        chk("grant_owner", 32'(grant_id), i);
        if (first_hs_cyc[i] < 0) first_hs_cyc[i] = cyc;
        last_hs_cyc[i] = cyc;
        hs_mask[i] = 1'b1;
      end
    end
    if (tx_valid && tx_ready) begin
      beat_cyc.push_back(cyc);
      chk("tx_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
    end
    prev_stall = tx_valid && !tx_ready;
    prev_data  = tx_data;
  endtask

  task automatic step();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) if (hs_mask[i]) void'(drv_q[i].pop_front());
    if (rand_ready) tx_ready = ($urandom_range(0, 9) < 7);
    drive();
  endtask

  task automatic run_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || drv_pending() || busy) && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_drained"}, 32'(n < budget), 1);
  endtask

  task automatic clear_marks();
    for (int i = 0; i < N; i++) begin
      first_hs_cyc[i] = -1;
      last_hs_cyc[i]  = -1;
    end
    beat_cyc.delete();
  endtask

  task automatic do_reset(input int cycles);
    rst_i = 1'b0;
    for (int i = 0; i < N; i++) begin
      drv_q[i].delete();
      pend_q[i].delete();
    end
    exp_q.delete();
    model_rr   = 0;
    prev_stall = 1'b0;
    drive();
    repeat (cycles) step();
    rst_i = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int n;
    rst_i        = 1'b0;
    tx_ready     = 1'b0;
    req_valid    = '0;
    req_data     = '0;
    req_last     = '0;
    forbid_ready = '0;
    hs_mask      = '0;
    rand_ready   = 1'b0;
    prev_stall   = 1'b0;
    prev_data    = '0;
`ifdef ARB_TIMEOUT_EN
    to_pulses = 0;
    to_cyc    = -1;
    prev_to   = 1'b0;
`endif
    clear_marks();

    // Reset values
    do_reset(2);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_timeout", 32'(timeout_err), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_rr", 32'(dut.rr_ptr_q), 0);

    // Single message from requester 2 at full rate
    tx_ready = 1'b1;
    clear_marks();
    add_byte(2, 8'h41, 1'b0);
    add_byte(2, 8'h42, 1'b0);
    add_byte(2, 8'h43, 1'b1);
    model_resolve();
    c0 = cyc;
    drive();
    run_idle("single", 50);
    chk("single_ready_lat", 32'(first_hs_cyc[2]), 32'(c0 + 1));
    chk("single_beats", 32'(beat_cyc.size()), 3);
    if (beat_cyc.size() == 3) begin
      chk("single_first_beat", 32'(beat_cyc[0]), 32'(c0 + 2));
      chk("single_last_beat", 32'(beat_cyc[2]), 32'(c0 + 4));
    end
    chk("single_rr", 32'(dut.rr_ptr_q), 3);
    chk("single_busy", 32'(busy), 0);

    // Contention from reset, then a reload, then a pointer left at 1
    do_reset(1);
    clear_marks();
    add_msg(0, 2);
    add_msg(1, 2);
    model_resolve();
    drive();
    run_idle("fair1", 60);
    chk("fair1_order", 32'(first_hs_cyc[0] < first_hs_cyc[1]), 1);
    chk("fair1_rr", 32'(dut.rr_ptr_q), 2);
    clear_marks();
    add_msg(0, 2);
    add_msg(1, 2);
    model_resolve();
    drive();
    run_idle("fair2", 60);
    chk("fair2_order", 32'(first_hs_cyc[0] < first_hs_cyc[1]), 1);
    add_msg(0, 1);
    model_resolve();
    drive();
    run_idle("fair3", 30);
    chk("fair3_rr", 32'(dut.rr_ptr_q), 1);
    clear_marks();
    add_msg(0, 2);
    add_msg(1, 2);
    model_resolve();
    drive();
    run_idle("fair4", 60);
    chk("fair4_req1_first", 32'(first_hs_cyc[1] < first_hs_cyc[0]), 1);

    // Backpressure for 5 cycles in the middle of a 4-byte message
    clear_marks();
    add_msg(0, 4);
    model_resolve();
    drive();
    n = 0;
    while (beat_cyc.size() < 2 && n < 20) begin
      step();
      n++;
    end
    chk("bp_started", 32'(n < 20), 1);
    tx_ready = 1'b0;
    repeat (5) step();
    tx_ready = 1'b1;
    run_idle("bp", 40);
    chk("bp_beats", 32'(beat_cyc.size()), 4);

    // Requester 3 arrives while requester 1 is mid-message
    clear_marks();
    add_msg(1, 4);
    model_resolve();
    drive();
    repeat (3) step();
    add_msg(3, 2);
    model_resolve();
    forbid_ready = 4'b1000;
    drive();
    n = 0;
    while (drv_q[1].size() > 0 && n < 30) begin
      step();
      n++;
    end
    forbid_ready = '0;
    chk("ni_req1_done", 32'(n < 30), 1);
    run_idle("ni", 40);
    chk("ni_gap", 32'(first_hs_cyc[3]), 32'(last_hs_cyc[1] + 2));

    // Randomized traffic with random serializer backpressure
    for (int round = 0; round < 4; round++) begin
      for (int r = 0; r < N; r++) begin
        for (int m = $urandom_range(0, 2); m > 0; m--) add_msg(r, $urandom_range(1, 6));
      end
      model_resolve();
      rand_ready = 1'b1;
      drive();
      run_idle("rand", 2000);
      rand_ready = 1'b0;
      tx_ready   = 1'b1;
    end

    // Reset while a byte sits in the output register
    add_msg(2, 6);
    model_resolve();
    drive();
    n = 0;
    while (!tx_valid && n < 20) begin
      step();
      n++;
    end
    chk("mid_rst_loaded", 32'(tx_valid), 1);
    do_reset(1);
    chk("mid_rst_tx_valid", 32'(tx_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_grant", 32'(grant_id), 0);
    chk("mid_rst_rr", 32'(dut.rr_ptr_q), 0);
    repeat (4) step();

`ifdef ARB_TIMEOUT_EN
    // Owner stops after one byte and is evicted; a waiting requester then wins
    clear_marks();
    to_pulses = 0;
    drv_q[0].push_back({1'b0, 8'h5A});
    exp_q.push_back(8'h5A);
    drive();
    repeat (2) step();
    add_msg(2, 3);
    model_resolve();
    drive();
    run_idle("to", 100);
    chk("to_pulses", 32'(to_pulses), 1);
    chk("to_when", 32'(to_cyc), 32'(last_hs_cyc[0] + 9));
    chk("to_next_grant", 32'(first_hs_cyc[2]), 32'(to_cyc + 1));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
